qam16_demap: RTL and testbench

Receive-side counterpart of the 16-QAM IQ mapper. It hard-slices each incoming (xr, xi) sample pair to a 4-bit symbol and packs 32 symbols MSB-first into a 128-bit word. Completed words go through a one-word output register to the downstream word writer, with backpressure. It sits between the equaliser/sample path and the receive-side writer FIFO.

---
 rtl/qam16_pkg.sv | 18 +
 rtl/qam16_slice_axis.sv | 18 +
 rtl/qam16_demap.sv | 114 +++++++++++
 tb/tb_qam16_demap.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qam16_pkg.sv
// Shared 16-QAM constants: constellation levels, slicer thresholds and word packing.
package qam16_pkg;

  localparam int SYM_PER_WORD = 32;
  localparam int WORD_W       = 4 * SYM_PER_WORD;
  localparam int CNT_W        = $clog2(SYM_PER_WORD);

  localparam logic signed [10:0] LVL_P3 = 11'sd1023;
  localparam logic signed [10:0] LVL_P1 = 11'sd341;
  localparam logic signed [10:0] LVL_N1 = -11'sd342;
  localparam logic signed [10:0] LVL_N3 = 11'sh400;

  localparam logic signed [10:0] THR_HI = 11'sd682;
  localparam logic signed [10:0] THR_LO = -11'sd683;

  typedef logic [3:0] sym_t;

endpackage

// File: rtl/qam16_slice_axis.sv
// Hard slicer for one axis: sign bit and inner/outer decision.
module qam16_slice_axis
  import qam16_pkg::*;
(
  input  logic [10:0] i_x,
  output logic        o_sign,
  output logic        o_inner
);

  localparam logic signed [10:0] THR_HI_M1 = THR_HI - 11'sd1;

  logic signed [10:0] w_x;

  assign w_x     = $signed(i_x);
  assign o_sign  = i_x[10];
  assign o_inner = (w_x >= THR_LO) && (w_x <= THR_HI_M1);

endmodule

// File: rtl/qam16_demap.sv
// 16-QAM hard demapper: slices (xr, xi) pairs into nibbles and packs 32 per
// 128-bit word, MSB first, handing words to the writer through one output register.
module qam16_demap
  import qam16_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              ce,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [10:0]       xr,
  input  logic [10:0]       xi,
  input  logic              flush,
  output logic [WORD_W-1:0] writer_data,
  output logic              writer_en,
  input  logic              writer_full,
  output logic [3:0]        raw,
  output logic              valid_raw,
  output logic [15:0]       words_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYM_PER_WORD - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] r_out;
  logic              r_out_valid;
  logic              r_flush_pend;
  sym_t              r_raw;
  logic              r_valid_raw;
  logic [15:0]       r_words;

  logic              w_xr_sign, w_xr_inner, w_xi_sign, w_xi_inner;
  sym_t              w_sym;
  logic              w_run;
  logic              w_accept;
  logic              w_wr_en;
  logic              w_can_load;
  logic              w_last;
  logic              w_flush_req;
  logic              w_flush_do;
  logic              w_load;
  logic [WORD_W-1:0] w_asm_next;

  qam16_slice_axis u_slice_xr (.i_x(xr), .o_sign(w_xr_sign), .o_inner(w_xr_inner));
  qam16_slice_axis u_slice_xi (.i_x(xi), .o_sign(w_xi_sign), .o_inner(w_xi_inner));

  assign w_sym = {w_xr_sign, w_xi_sign, w_xr_inner, w_xi_inner};

  // RST is folded in so the handshake outputs read 0 while reset is held
  assign w_run      = ce & RST;
  assign w_wr_en    = w_run & r_out_valid & ~writer_full;
  assign w_can_load = ~r_out_valid | w_wr_en;
  assign ready_o    = w_run & ~r_flush_pend &
                      ((r_cnt != LAST_IDX) | ~r_out_valid | ~writer_full);
  assign w_accept   = valid_i & ready_o;
  assign w_last     = w_accept & (r_cnt == LAST_IDX);

  // A flush only counts when the word would hold at least one symbol
  assign w_flush_req = w_run & (flush | r_flush_pend) & ((r_cnt != '0) | w_accept);
  assign w_flush_do  = w_flush_req & w_can_load;
  assign w_load      = w_last | w_flush_do;

  always_comb begin
    w_asm_next = r_asm;
    if (w_accept) begin
      w_asm_next[WORD_W - 1 - 4 * int'(r_cnt) -: 4] = w_sym;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt        <= '0;
      r_asm        <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_flush_pend <= 1'b0;
      r_raw        <= '0;
      r_valid_raw  <= 1'b0;
      r_words      <= '0;
    end else begin
      r_valid_raw <= w_accept;
      if (w_accept) begin
        r_raw <= w_sym;
      end
      if (w_load) begin
        r_out <= w_asm_next;
        r_asm <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_asm <= w_asm_next;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (w_wr_en) begin
        r_out_valid <= 1'b0;
      end
      if (w_run) begin
        r_flush_pend <= w_flush_req & ~w_load;
      end
      if (w_wr_en) begin
        r_words <= r_words + 16'd1;
      end
    end
  end

  assign writer_data = r_out;
  assign writer_en   = w_wr_en;
  assign raw         = r_raw;
  assign valid_raw   = r_valid_raw & w_run;
  assign words_o     = r_words;

endmodule

// File: tb/tb_qam16_demap.sv
// Directed self-checking bench for qam16_demap.
module tb_qam16_demap;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ce, valid_i, flush, writer_full;
  logic [10:0]   xr, xi;
  logic          ready_o, writer_en, valid_raw;
  logic [127:0]  writer_data;
  logic [3:0]    raw;
  logic [15:0]   words_o;

  int n_checks = 0;
  int n_err    = 0;
  int exp_words = 0;
  int raw_sz;

  logic [127:0] wr_q[$];
  logic [3:0]   raw_q[$];

  logic [127:0] w_clean, w_a, w_b, w_c;
  logic [10:0]  tv[6];
  logic [3:0]   exp_r[6];
  logic [3:0]   exp_i[6];

  qam16_demap dut (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .ready_o(ready_o),
    .xr(xr), .xi(xi), .flush(flush), .writer_data(writer_data),
    .writer_en(writer_en), .writer_full(writer_full), .raw(raw),
    .valid_raw(valid_raw), .words_o(words_o)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (writer_en) wr_q.push_back(writer_data);
    if (valid_raw) raw_q.push_back(raw);
  end

  function automatic logic [10:0] lvl(input logic s, input logic inn);
    case ({s, inn})
      2'b00:   return 11'd1023;
      2'b01:   return 11'd341;
      2'b10:   return 11'h400;
      default: return 11'h6AA;
    endcase
  endfunction

  function automatic logic [3:0] nib_of(input logic [127:0] w, input int k);
    return w[127 - 4 * k -: 4];
  endfunction

  function automatic logic [127:0] mkword(input int base, input int mul, input int add);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < 32; j++) w[127 - 4 * j -: 4] = 4'(((base + j) * mul + add) % 16);
    return w;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_xy(input logic [10:0] a, input logic [10:0] b, input logic fl);
    bit done;
    done = 1'b0;
    xr = a; xi = b; valid_i = 1'b1; flush = fl;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (ready_o) done = 1'b1;
      cyc();
    end
    chk("send_accepted", 128'(done), 128'd1);
    valid_i = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send(input logic [3:0] n, input logic fl);
    send_xy(lvl(n[3], n[1]), lvl(n[2], n[0]), fl);
  endtask

  initial begin
    ce = 1'b1; valid_i = 1'b1; flush = 1'b0; writer_full = 1'b0; xr = '0; xi = '0;
    w_clean = 128'h0123456789ABCDEFFEDCBA9876543210;
    w_a = mkword(0, 7, 3);
    w_b = mkword(32, 7, 3);
    w_c = mkword(0, 1, 5);
    tv    = '{11'd682, 11'd681, 11'd0, 11'h7FF, 11'h555, 11'h554};
    exp_r = '{4'h0, 4'h2, 4'h2, 4'hA, 4'hA, 4'h8};
    exp_i = '{4'h0, 4'h1, 4'h1, 4'h5, 4'h5, 4'h4};

    // reset from power-up
    repeat (3) cyc();
    chk("rst_ready", 128'(ready_o), 0);
    chk("rst_wen", 128'(writer_en), 0);
    chk("rst_vraw", 128'(valid_raw), 0);
    chk("rst_raw", 128'(raw), 0);
    chk("rst_words", 128'(words_o), 0);
    chk("rst_data", writer_data, 0);
    RST = 1'b1;
    cyc();

    // reset asserted mid-word discards the partial word
    for (int k = 0; k < 10; k++) send(4'(k), 1'b0);
    RST = 1'b0;
    valid_i = 1'b1;
    #1;
    chk("midrst_ready", 128'(ready_o), 0);
    chk("midrst_data", writer_data, 0);
    chk("midrst_raw", 128'(raw), 0);
    repeat (3) begin
      chk("midrst_wen", 128'(writer_en), 0);
      cyc();
    end
    valid_i = 1'b0;
    RST = 1'b1;
    cyc();
    wr_q.delete();
    raw_q.delete();

    // clean constellation word
    for (int k = 0; k < 32; k++) send(nib_of(w_clean, k), 1'b0);
    chk("clean_wen", 128'(writer_en), 1);
    chk("clean_data", writer_data, w_clean);
    cyc();
    exp_words++;
    chk("clean_wen_once", 128'(writer_en), 0);
    chk("clean_words", 128'(words_o), 128'(exp_words));
    chk("clean_wrq", 128'(wr_q.size()), 128'(exp_words));
    chk("clean_rawn", 128'(raw_q.size()), 32);
    for (int k = 0; k < 32 && k < raw_q.size(); k++)
      chk("clean_rawseq", 128'(raw_q[k]), 128'(nib_of(w_clean, k)));

    // slicer thresholds on each axis
    for (int i = 0; i < 6; i++) begin
      send_xy(tv[i], 11'd1023, 1'b0);
      chk("thr_xr", 128'(raw), 128'(exp_r[i]));
    end
    for (int i = 0; i < 6; i++) begin
      send_xy(11'd1023, tv[i], 1'b0);
      chk("thr_xi", 128'(raw), 128'(exp_i[i]));
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("thr_flush_wen", 128'(writer_en), 1);
    chk("thr_flush_data", writer_data, 128'h022AA801_15540000_00000000_00000000);
    cyc();
    exp_words++;
    chk("thr_words", 128'(words_o), 128'(exp_words));

    // flush after 5 symbols
    for (int k = 0; k < 5; k++) send(4'hF, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush5_wen", 128'(writer_en), 1);
    chk("flush5_data", writer_data, 128'hFFFFF000_00000000_00000000_00000000);
    cyc();
    exp_words++;

    // flush concurrent with the 6th symbol
    for (int k = 0; k < 5; k++) send(4'hF, 1'b0);
    send(4'hF, 1'b1);
    chk("flush6_wen", 128'(writer_en), 1);
    chk("flush6_data", writer_data, 128'hFFFFFF00_00000000_00000000_00000000);
    cyc();
    exp_words++;
    chk("flush6_words", 128'(words_o), 128'(exp_words));

    // flush with nothing assembled
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush0_wen_a", 128'(writer_en), 0);
    cyc();
    chk("flush0_wen_b", 128'(writer_en), 0);
    chk("flush0_words", 128'(words_o), 128'(exp_words));

    // backpressure across two words
    writer_full = 1'b1;
    for (int k = 0; k < 32; k++) send(nib_of(w_a, k), 1'b0);
    for (int k = 0; k < 31; k++) send(nib_of(w_b, k), 1'b0);
    xr = lvl(w_b[3], w_b[1]);
    xi = lvl(w_b[2], w_b[0]);
    valid_i = 1'b1;
    #1;
    chk("bp_ready_low", 128'(ready_o), 0);
    repeat (3) cyc();
    chk("bp_ready_hold", 128'(ready_o), 0);
    chk("bp_wen_blocked", 128'(writer_en), 0);
    writer_full = 1'b0;
    #1;
    chk("bp_ready_release", 128'(ready_o), 1);
    chk("bp_wen_a", 128'(writer_en), 1);
    chk("bp_data_a", writer_data, w_a);
    cyc();
    valid_i = 1'b0;
    chk("bp_wen_b", 128'(writer_en), 1);
    chk("bp_data_b", writer_data, w_b);
    cyc();
    exp_words += 2;
    chk("bp_words", 128'(words_o), 128'(exp_words));
    chk("bp_wrq", 128'(wr_q.size()), 128'(exp_words));
    if (wr_q.size() >= 2) begin
      chk("bp_order_a", wr_q[wr_q.size() - 2], w_a);
      chk("bp_order_b", wr_q[wr_q.size() - 1], w_b);
    end

    // clock-enable gap mid-word
    for (int k = 0; k < 10; k++) send(nib_of(w_c, k), 1'b0);
    ce = 1'b0;
    xr = lvl(w_c[127 - 40], w_c[127 - 42]);
    xi = lvl(w_c[127 - 41], w_c[127 - 43]);
    valid_i = 1'b1;
    raw_sz = raw_q.size();
    repeat (3) begin
      #1;
      chk("ce_ready", 128'(ready_o), 0);
      chk("ce_vraw", 128'(valid_raw), 0);
      chk("ce_wen", 128'(writer_en), 0);
      cyc();
    end
    chk("ce_raw_none", 128'(raw_q.size()), 128'(raw_sz));
    ce = 1'b1;
    for (int k = 10; k < 32; k++) send(nib_of(w_c, k), 1'b0);
    chk("ce_wen_done", 128'(writer_en), 1);
    chk("ce_data", writer_data, w_c);
    cyc();
    exp_words++;
    chk("ce_words", 128'(words_o), 128'(exp_words));
    chk("ce_wrq", 128'(wr_q.size()), 128'(exp_words));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
